// File: rtl/mem_access_ctrl.sv
// Command-driven initiator for the 16x8 dual-read data memory.
// Sequences write, read pair, copy and block fill; one command at a time.
module mem_access_ctrl #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmdValid,
    output logic              cmdReady,
    input  logic [1:0]        cmdOp,
    input  logic [ADDR_W-1:0] cmdAddrA,
    input  logic [ADDR_W-1:0] cmdAddrB,
    input  logic [DATA_W-1:0] cmdData,
    input  logic [ADDR_W-1:0] cmdCount,
    output logic              rspValid,
    output logic [DATA_W-1:0] rspData1,
    output logic [DATA_W-1:0] rspData2,
    output logic              busy,
    output logic              memWriteEnable,
    output logic [ADDR_W-1:0] memWriteAddress,
    output logic [DATA_W-1:0] memWriteData,
    output logic [ADDR_W-1:0] memReadAddress1,
    output logic [ADDR_W-1:0] memReadAddress2,
    input  logic [DATA_W-1:0] memReadData1,
    input  logic [DATA_W-1:0] memReadData2
);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_COPY  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        CPW,
        FILL,
        RESP
    } stateT;

    stateT             state;
    logic [1:0]        opReg;
    logic [ADDR_W-1:0] addrB;
    logic [ADDR_W-1:0] count;
    logic [ADDR_W-1:0] idx;

    // Memory drive is loaded on the transition into each state, so every mem* pin is a flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            opReg           <= '0;
            addrB           <= '0;
            count           <= '0;
            idx             <= '0;
            cmdReady        <= 1'b0;
            rspValid        <= 1'b0;
            rspData1        <= '0;
            rspData2        <= '0;
            busy            <= 1'b0;
            memWriteEnable  <= 1'b0;
            memWriteAddress <= '0;
            memWriteData    <= '0;
            memReadAddress1 <= '0;
            memReadAddress2 <= '0;
        end else begin
            rspValid <= 1'b0;
            case (state)
                IDLE: begin
                    cmdReady <= 1'b1;
                    if (cmdValid && cmdReady) begin
                        cmdReady <= 1'b0;
                        busy     <= 1'b1;
                        opReg    <= cmdOp;
                        addrB    <= cmdAddrB;
                        count    <= cmdCount;
                        idx      <= '0;
                        case (cmdOp)
                            OP_WRITE: begin
                                state           <= WR;
                                memWriteEnable  <= 1'b1;
                                memWriteAddress <= cmdAddrA;
                                memWriteData    <= cmdData;
                            end
                            OP_READ: begin
                                state           <= RD;
                                memReadAddress1 <= cmdAddrA;
                                memReadAddress2 <= cmdAddrB;
                            end
                            OP_COPY: begin
                                state           <= RD;
                                memReadAddress1 <= cmdAddrA;
                            end
                            default: begin
                                state           <= FILL;
                                memWriteEnable  <= 1'b1;
                                memWriteAddress <= cmdAddrA;
                                memWriteData    <= cmdData;
                            end
                        endcase
                    end
                end
                WR, CPW: begin
                    memWriteEnable <= 1'b0;
                    rspData1       <= memWriteData;
                    rspData2       <= '0;
                    rspValid       <= 1'b1;
                    state          <= RESP;
                end
                RD: begin
                    memReadAddress1 <= '0;
                    memReadAddress2 <= '0;
                    if (opReg == OP_READ) begin
                        rspData1 <= memReadData1;
                        rspData2 <= memReadData2;
                        rspValid <= 1'b1;
                        state    <= RESP;
                    end else begin
                        // Copy: the write-data flop doubles as the temp holding the source value.
                        memWriteEnable  <= 1'b1;
                        memWriteAddress <= addrB;
                        memWriteData    <= memReadData1;
                        state           <= CPW;
                    end
                end
                FILL: begin
                    if (idx == count) begin
                        memWriteEnable <= 1'b0;
                        rspData1       <= memWriteData;
                        rspData2       <= DATA_W'(count);
                        rspValid       <= 1'b1;
                        state          <= RESP;
                    end else begin
                        idx             <= idx + ADDR_W'(1);
                        memWriteAddress <= memWriteAddress + ADDR_W'(1);
                        memWriteData    <= memWriteData + DATA_W'(1);
                    end
                end
                RESP: begin
                    busy     <= 1'b0;
                    cmdReady <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl with a memory model and a command-level reference.
module tb_mem_access_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmdValid = 1'b0;
    logic [1:0] cmdOp = '0;
    logic [3:0] cmdAddrA = '0;
    logic [3:0] cmdAddrB = '0;
    logic [7:0] cmdData = '0;
    logic [3:0] cmdCount = '0;
    logic       cmdReady, rspValid, busy, memWriteEnable;
    logic [7:0] rspData1, rspData2, memWriteData, memReadData1, memReadData2;
    logic [3:0] memWriteAddress, memReadAddress1, memReadAddress2;

    logic [7:0] mem [16] = '{default: 8'h00};
    logic [7:0] refMem [16] = '{default: 8'h00};
    int wrCount = 0;
    int total = 0;
    int bad = 0;

    mem_access_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .reset(reset),
        .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOp(cmdOp),
        .cmdAddrA(cmdAddrA), .cmdAddrB(cmdAddrB), .cmdData(cmdData), .cmdCount(cmdCount),
        .rspValid(rspValid), .rspData1(rspData1), .rspData2(rspData2), .busy(busy),
        .memWriteEnable(memWriteEnable), .memWriteAddress(memWriteAddress),
        .memWriteData(memWriteData), .memReadAddress1(memReadAddress1),
        .memReadAddress2(memReadAddress2), .memReadData1(memReadData1),
        .memReadData2(memReadData2)
    );

    always #5 clk = ~clk;

    // Data memory: synchronous write, combinational reads.
    always @(posedge clk) begin
        if (memWriteEnable) begin
            mem[memWriteAddress] <= memWriteData;
            wrCount <= wrCount + 1;
        end
    end
    assign memReadData1 = mem[memReadAddress1];
    assign memReadData2 = mem[memReadAddress2];

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic checkMem(input string tag);
        for (int i = 0; i < 16; i++) checkEq(tag, 64'(mem[i]), 64'(refMem[i]));
    endtask

    task automatic checkAllZero(input string tag);
        checkEq(tag, 64'({cmdReady, rspValid, busy, memWriteEnable, rspData1, rspData2}), 64'(0));
        checkEq(tag, 64'({memWriteAddress, memReadAddress1, memReadAddress2, memWriteData}), 64'(0));
    endtask

    task automatic randomizeFields();
        cmdOp    = 2'($urandom_range(0, 3));
        cmdAddrA = 4'($urandom);
        cmdAddrB = 4'($urandom);
        cmdData  = 8'($urandom);
        cmdCount = 4'($urandom);
    endtask

    // Issue one command from a negedge; returns at the negedge after the response cycle.
    task automatic doCmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] d, input logic [3:0] c, input bit hold);
        logic [7:0] e1, e2;
        int expLat, expWe, wes, k;
        bit seen;
        e2 = 8'h00;
        case (op)
            2'b00: begin refMem[a] = d; e1 = d; expLat = 1; expWe = 1; end
            2'b01: begin e1 = refMem[a]; e2 = refMem[b]; expLat = 1; expWe = 0; end
            2'b10: begin e1 = refMem[a]; refMem[b] = e1; expLat = 2; expWe = 1; end
            default: begin
                for (int i = 0; i <= int'(c); i++) refMem[4'(int'(a) + i)] = 8'(int'(d) + i);
                e1 = 8'(int'(d) + int'(c));
                e2 = 8'(c);
                expLat = int'(c) + 1;
                expWe = int'(c) + 1;
            end
        endcase
        k = 0;
        while (!cmdReady && k < 20) begin @(negedge clk); k++; end
        checkEq("readyBeforeCmd", 64'(cmdReady), 64'(1));
        cmdValid = 1'b1; cmdOp = op; cmdAddrA = a; cmdAddrB = b; cmdData = d; cmdCount = c;
        @(posedge clk);
        @(negedge clk);
        checkEq("busyAfterAccept", 64'({busy, cmdReady}), 64'(2'b10));
        wes = 0;
        seen = 1'b0;
        for (k = 1; k <= 40; k++) begin
            if (rspValid) begin seen = 1'b1; break; end
            if (memWriteEnable) wes++;
            randomizeFields();
            cmdValid = hold;
            @(negedge clk);
        end
        cmdValid = 1'b0;
        checkEq("rspSeen", 64'(seen), 64'(1));
        checkEq("latency", 64'(k - 1), 64'(expLat));
        checkEq("weCycles", 64'(wes), 64'(expWe));
        checkEq("rspData1", 64'(rspData1), 64'(e1));
        checkEq("rspData2", 64'(rspData2), 64'(e2));
        checkEq("portsIdleInResp", 64'({memWriteEnable, memReadAddress1, memReadAddress2}), 64'(0));
        @(negedge clk);
        checkEq("rspOneCycle", 64'({rspValid, busy, cmdReady}), 64'(3'b001));
        checkMem("memContents");
    endtask

    initial begin
        int wc0;
        #1 reset = 1'b0;
        #2 checkAllZero("resetOutputs");
        #9 checkAllZero("resetOutputsAfterEdge");
        #10 reset = 1'b1;
        @(negedge clk);
        checkEq("readyAfterReset", 64'({cmdReady, busy}), 64'(2'b10));
        checkEq("noWritesInReset", 64'(wrCount), 64'(0));

        doCmd(2'b00, 4'h0, 4'h0, 8'h11, 4'h0, 1'b0);
        doCmd(2'b00, 4'h3, 4'h0, 8'h71, 4'h0, 1'b0);
        doCmd(2'b01, 4'h3, 4'h0, 8'h00, 4'h0, 1'b0);
        doCmd(2'b10, 4'h3, 4'h9, 8'h00, 4'h0, 1'b0);
        doCmd(2'b01, 4'h9, 4'h3, 8'h00, 4'h0, 1'b0);
        doCmd(2'b11, 4'hE, 4'h0, 8'hFE, 4'h3, 1'b0);
        doCmd(2'b01, 4'h0, 4'hF, 8'h00, 4'h0, 1'b0);
        doCmd(2'b00, 4'h5, 4'h0, 8'hA5, 4'h0, 1'b1);
        doCmd(2'b10, 4'h7, 4'h7, 8'h00, 4'h0, 1'b1);
        doCmd(2'b01, 4'hE, 4'hE, 8'h00, 4'h0, 1'b0);
        doCmd(2'b11, 4'h0, 4'h0, 8'hF8, 4'hF, 1'b0);
        doCmd(2'b01, 4'h7, 4'h8, 8'h00, 4'h0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            doCmd(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 8'($urandom),
                  4'($urandom), ($urandom_range(0, 3) == 0));
        end

        // Abort a 16-location fill after its fifth committed write.
        wc0 = wrCount;
        cmdValid = 1'b1; cmdOp = 2'b11; cmdAddrA = 4'h6; cmdAddrB = 4'h0;
        cmdData = 8'h30; cmdCount = 4'hF;
        @(posedge clk);
        @(negedge clk);
        cmdValid = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) refMem[4'(6 + i)] = 8'(8'h30 + i);
        #1 checkAllZero("abortOutputs");
        seenAbortRsp: begin
            int rs;
            rs = 0;
            repeat (3) begin @(negedge clk); if (rspValid) rs++; end
            checkEq("noRspWhileReset", 64'(rs), 64'(0));
        end
        checkEq("abortWriteCount", 64'(wrCount - wc0), 64'(5));
        reset = 1'b1;
        @(negedge clk);
        checkEq("readyAfterAbort", 64'({cmdReady, rspValid}), 64'(2'b10));
        checkMem("memAfterAbort");
        doCmd(2'b01, 4'h6, 4'hB, 8'h00, 4'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
